// File: rtl/hub75_rx_if.sv
// hub75_rx_if: HUB75 panel lines in, captured pixel/latch/on-time event streams out.
interface hub75_rx_if #(
   parameter int COL_W    = 7,
   parameter int ROW_W    = 6,
   parameter int BIT_W    = 3,
   parameter int ONTIME_W = 16
);
   logic [11:0]         rgb_in;
   logic                clk_in;
   logic                lat_in;
   logic                blank_in;
   logic                row_clk_in;
   logic                row_data_in;
   logic                px_valid;
   logic [COL_W-1:0]    px_col;
   logic [11:0]         px_data;
   logic                lat_valid;
   logic [ROW_W-1:0]    lat_row;
   logic [BIT_W-1:0]    lat_bit;
   logic [COL_W:0]      lat_cols;
   logic                lat_err;
   logic                ontime_valid;
   logic [ONTIME_W-1:0] ontime_cycles;
   modport master (
      output rgb_in, clk_in, lat_in, blank_in, row_clk_in, row_data_in,
      input  px_valid, px_col, px_data, lat_valid, lat_row, lat_bit, lat_cols, lat_err,
             ontime_valid, ontime_cycles
   );
   modport slave (
      input  rgb_in, clk_in, lat_in, blank_in, row_clk_in, row_data_in,
      output px_valid, px_col, px_data, lat_valid, lat_row, lat_bit, lat_cols, lat_err,
             ontime_valid, ontime_cycles
   );
endinterface

// File: rtl/hub75_rx.sv
// hub75_rx: oversampling HUB75 capture/decoder producing pixel, latch and on-time events.
// Define HUB75_RX_GLITCH_FILTER_EN to reject single-sample pulses on clk/lat/row_clk.
module hub75_rx #(
   parameter int COLS     = 64,
   parameter int COL_W    = 7,
   parameter int ROW_W    = 6,
   parameter int BIT_W    = 3,
   parameter int ONTIME_W = 16
) (
   input logic       sys_clk,
   input logic       rst,
   hub75_rx_if.slave bus
);
`ifdef HUB75_RX_GLITCH_FILTER_EN
   localparam int RD = 3;
`else
   localparam int RD = 2;
`endif
   logic [2:0]         clk_s, lat_s, rclk_s, blank_s;
   logic [RD-1:0]      rdat_s;
   logic [RD-1:0][11:0] rgb_s;
   logic               clk_rise, lat_rise, rclk_rise, blank_rise, blank_fall;
   logic [11:0]        rgb;
   logic               rdat;
   logic [COL_W-1:0]   col_cnt, col_nxt;
   logic [ROW_W-1:0]   row_cnt, row_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_base;
   logic [ONTIME_W-1:0] ont_cnt;
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         clk_s   <= '0;
         lat_s   <= '0;
         rclk_s  <= '0;
         blank_s <= '1;
         rdat_s  <= '0;
         rgb_s   <= '0;
      end else begin
         clk_s   <= {clk_s[1:0], bus.clk_in};
         lat_s   <= {lat_s[1:0], bus.lat_in};
         rclk_s  <= {rclk_s[1:0], bus.row_clk_in};
         blank_s <= {blank_s[1:0], bus.blank_in};
         rdat_s  <= {rdat_s[RD-2:0], bus.row_data_in};
         rgb_s   <= {rgb_s[RD-2:0], bus.rgb_in};
      end
   end
`ifdef HUB75_RX_GLITCH_FILTER_EN
   // Accepted levels only move once two consecutive samples agree.
   logic clk_f, lat_f, rclk_f;
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         clk_f  <= 1'b0;
         lat_f  <= 1'b0;
         rclk_f <= 1'b0;
      end else begin
         clk_f  <= (clk_s[1] == clk_s[2]) ? clk_s[1] : clk_f;
         lat_f  <= (lat_s[1] == lat_s[2]) ? lat_s[1] : lat_f;
         rclk_f <= (rclk_s[1] == rclk_s[2]) ? rclk_s[1] : rclk_f;
      end
   end
   assign clk_rise  = clk_s[1] & clk_s[2] & ~clk_f;
   assign lat_rise  = lat_s[1] & lat_s[2] & ~lat_f;
   assign rclk_rise = rclk_s[1] & rclk_s[2] & ~rclk_f;
`else
   assign clk_rise  = clk_s[1] & ~clk_s[2];
   assign lat_rise  = lat_s[1] & ~lat_s[2];
   assign rclk_rise = rclk_s[1] & ~rclk_s[2];
`endif
   assign rgb        = rgb_s[RD-1];
   assign rdat       = rdat_s[RD-1];
   assign blank_rise = blank_s[1] & ~blank_s[2];
   assign blank_fall = ~blank_s[1] & blank_s[2];
   // Row update resolves before the latch sees it; a coincident clk edge counts in the closing latch.
   always_comb begin
      row_nxt  = rclk_rise ? (rdat ? '0 : row_cnt + 1'b1) : row_cnt;
      bit_base = (row_nxt != row_cnt) ? '0 : bit_cnt;
      col_nxt  = clk_rise ? col_cnt + COL_W'(col_cnt != '1) : col_cnt;
   end
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         col_cnt           <= '0;
         row_cnt           <= '0;
         bit_cnt           <= '0;
         ont_cnt           <= '0;
         bus.px_valid      <= 1'b0;
         bus.px_col        <= '0;
         bus.px_data       <= '0;
         bus.lat_valid     <= 1'b0;
         bus.lat_row       <= '0;
         bus.lat_bit       <= '0;
         bus.lat_cols      <= '0;
         bus.lat_err       <= 1'b0;
         bus.ontime_valid  <= 1'b0;
         bus.ontime_cycles <= '0;
      end else begin
         bus.px_valid     <= clk_rise;
         bus.lat_valid    <= lat_rise;
         bus.ontime_valid <= blank_rise;
         if (clk_rise) begin
            bus.px_col  <= col_cnt;
            bus.px_data <= rgb;
         end
         if (lat_rise) begin
            bus.lat_row  <= row_nxt;
            bus.lat_bit  <= bit_base;
            bus.lat_cols <= {1'b0, col_nxt};
            bus.lat_err  <= {1'b0, col_nxt} != (COL_W+1)'(COLS);
         end
         if (blank_rise) bus.ontime_cycles <= ont_cnt;
         row_cnt <= row_nxt;
         col_cnt <= lat_rise ? '0 : col_nxt;
         bit_cnt <= lat_rise ? bit_base + 1'b1 : bit_base;
         ont_cnt <= blank_fall ? ONTIME_W'(1) : (~blank_s[1] ? ont_cnt + ONTIME_W'(ont_cnt != '1) : ont_cnt);
      end
   end
endmodule
